// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Gate-level one-bit full subtractor: diff = a - b - bin, bout is the borrow out.
module fullsubtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic axb;

  assign axb  = a ^ b;
  assign diff = axb ^ bin;
  // Borrow when b exceeds a, or when a and b are equal and a borrow arrives.
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bo;
  logic             accept, last_bit, handoff;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (cnt_q == LAST);
  assign handoff  = (state_q == DONE) && out_ready;

  fullsubtractor u_cell (
    .diff (cell_d),
    .bout (cell_bo),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (handoff)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    if (accept) begin
      a_sh_d   = a;
      b_sh_d   = b;
      a_sign_d = a[WIDTH-1];
      b_sign_d = b[WIDTH-1];
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
      res_d    = {cell_d, res_q[WIDTH-1:1]};
      borrow_d = cell_bo;
      // Hold at the last index so the counter never wraps.
      if (!last_bit) cnt_d = cnt_q + 1'b1;
    end
  end

  // Control-side datapath state that must come up clean from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operand/result shift registers; contents are don't-care outside RUN/DONE.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    res_q    <= res_d;
    a_sign_q <= a_sign_d;
    b_sign_q <= b_sign_d;
  end

  // Outputs decoded from registered state; result fields are zero outside DONE.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = out_valid ? res_q : '0;
    bout      = out_valid & borrow_q;
    zero      = out_valid & (res_q == '0);
    ovf       = out_valid & (a_sign_q ^ b_sign_q) & (res_q[WIDTH-1] ^ a_sign_q);
  end

endmodule
